// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit seven-segment driver with per-slot dead time and frame-synchronous double buffering.
// Defining SEVEN_SEG_LZB_EN adds the lz_blank port and leading-zero blanking.
`timescale 1ns/1ps
module seven_seg_scanner #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int DEAD_CYCLES = 1000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
`ifdef SEVEN_SEG_LZB_EN
   input  logic                    lz_blank,
`endif
   output logic [NUM_DIGITS-1:0]   dig_n,
   output logic [7:0]              seg,
   output logic                    frame_done
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   function automatic logic [6:0] decode(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0: g = 7'h3F;
         4'h1: g = 7'h06;
         4'h2: g = 7'h5B;
         4'h3: g = 7'h4F;
         4'h4: g = 7'h66;
         4'h5: g = 7'h6D;
         4'h6: g = 7'h7D;
         4'h7: g = 7'h07;
         4'h8: g = 7'h7F;
         4'h9: g = 7'h6F;
         4'hA, 4'hB, 4'hC, 4'hD, 4'hE: g = 7'h40;
         default: g = 7'h00;
      endcase
      return g;
   endfunction

`ifdef SEVEN_SEG_LZB_EN
   // Blank from the top digit down while nibble and dp are both zero; digit 0 always stays lit.
   function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input logic [4*NUM_DIGITS-1:0] b,
                                                            input logic [NUM_DIGITS-1:0]   d);
      logic [NUM_DIGITS-1:0] mask;
      logic                  run;
      mask = {NUM_DIGITS{1'b0}};
      run  = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         if (run && (b[4*i +: 4] == 4'h0) && !d[i]) begin
            mask[i] = 1'b1;
         end else begin
            run = 1'b0;
         end
      end
      return mask;
   endfunction
`endif

   logic [CNT_W-1:0]        cnt;
   logic [IDX_W-1:0]        idx;
   logic [4*NUM_DIGITS-1:0] pend_bcd, disp_bcd, disp_bcd_nxt;
   logic [NUM_DIGITS-1:0]   pend_dp, disp_dp, disp_dp_nxt;
   logic [NUM_DIGITS-1:0]   blank_mask, dig_nxt;
   logic [3:0]              nib_nxt [NUM_DIGITS];
   logic                    pend_valid, boundary, in_dead;
   logic [7:0]              seg_nxt;

   // Frame-boundary commit and next-cycle pin values; decoding uses the post-commit display so a frame never mixes values.
   always_comb begin
      boundary     = (cnt == {CNT_W{1'b0}}) && (idx == {IDX_W{1'b0}});
      disp_bcd_nxt = disp_bcd;
      disp_dp_nxt  = disp_dp;
      if (boundary && pend_valid) begin
         disp_bcd_nxt = pend_bcd;
         disp_dp_nxt  = pend_dp;
      end else begin
         disp_bcd_nxt = disp_bcd;
         disp_dp_nxt  = disp_dp;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         nib_nxt[i] = disp_bcd_nxt[4*i +: 4];
      end
`ifdef SEVEN_SEG_LZB_EN
      blank_mask = lz_blank ? lead_zero_mask(disp_bcd_nxt, disp_dp_nxt) : {NUM_DIGITS{1'b0}};
`else
      blank_mask = {NUM_DIGITS{1'b0}};
`endif
      in_dead = (int'(cnt) < DEAD_CYCLES);
      dig_nxt = {NUM_DIGITS{1'b1}};
      seg_nxt = 8'h00;
      if (!in_dead) begin
         dig_nxt[idx] = 1'b0;
         if (blank_mask[idx]) begin
            seg_nxt = 8'h00;
         end else begin
            seg_nxt = {disp_dp_nxt[idx], decode(nib_nxt[idx])};
         end
      end else begin
         dig_nxt = {NUM_DIGITS{1'b1}};
         seg_nxt = 8'h00;
      end
   end

   // Slot/digit counters, pending and display registers, and the registered pin outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= {CNT_W{1'b0}};
         idx        <= {IDX_W{1'b0}};
         pend_bcd   <= {(4*NUM_DIGITS){1'b0}};
         pend_dp    <= {NUM_DIGITS{1'b0}};
         pend_valid <= 1'b0;
         disp_bcd   <= {(4*NUM_DIGITS){1'b0}};
         disp_dp    <= {NUM_DIGITS{1'b0}};
         dig_n      <= {NUM_DIGITS{1'b1}};
         seg        <= 8'h00;
         frame_done <= 1'b0;
      end else begin
         if (cnt == CNT_LAST) begin
            cnt <= {CNT_W{1'b0}};
            idx <= (idx == IDX_LAST) ? {IDX_W{1'b0}} : idx + IDX_ONE;
         end else begin
            cnt <= cnt + CNT_ONE;
         end
         disp_bcd <= disp_bcd_nxt;
         disp_dp  <= disp_dp_nxt;
         // A load on the boundary edge survives into the next frame; the commit above used the older contents.
         if (load) begin
            pend_bcd   <= bcd_in;
            pend_dp    <= dp_in;
            pend_valid <= 1'b1;
         end else if (boundary) begin
            pend_valid <= 1'b0;
         end else begin
            pend_valid <= pend_valid;
         end
         dig_n      <= dig_nxt;
         seg        <= seg_nxt;
         frame_done <= boundary;
      end
   end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (4 digits, 8-cycle slots, 2 dead cycles) against a frame-position model.
`timescale 1ns/1ps
module tb_seven_seg_scanner;

   localparam int ND = 4, RD = 8, DC = 2, FRAME = ND * RD;

   logic        clk = 1'b0;
   logic        rst, load, lz_blank;
   logic [15:0] bcd_in;
   logic [3:0]  dp_in;
   logic [3:0]  dig_n;
   logic [7:0]  seg;
   logic        frame_done;

   always #5 clk = ~clk;

   seven_seg_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
      .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
`ifdef SEVEN_SEG_LZB_EN
      .lz_blank(lz_blank),
`endif
      .dig_n(dig_n), .seg(seg), .frame_done(frame_done));

   int          checks = 0, failures = 0;
   // Model: m_t counts non-reset edges since reset; position in frame is m_t mod FRAME.
   int          m_t;
   logic [15:0] m_pb, m_disp;
   logic [3:0]  m_pd, m_dpd;
   bit          m_pv;
   logic [3:0]  exp_dig;
   logic [7:0]  exp_seg;
   logic        exp_fd;
   logic [6:0]  glyph [16];
   logic [7:0]  got [ND];
   logic [3:0]  trace [FRAME];
   int          fd_cnt, mism;
   string       bad_msg;

   // One clock edge: advance the model with the inputs the DUT saw, then settle for sampling.
   task automatic tick();
      int p, d, w, top;
      @(posedge clk);
      if (rst) begin
         m_t = 0; m_pv = 0; m_pb = 16'h0; m_pd = 4'h0; m_disp = 16'h0; m_dpd = 4'h0;
         exp_dig = 4'hF; exp_seg = 8'h00; exp_fd = 1'b0;
      end else begin
         p = m_t % FRAME;
         if (p == 0) begin
            if (m_pv) begin m_disp = m_pb; m_dpd = m_pd; end
            m_pv = 0;
         end
         if (load) begin m_pb = bcd_in; m_pd = dp_in; m_pv = 1; end
         d = p / RD; w = p % RD;
         top = ND - 1;
         if (lz_blank) begin
            top = 0;
            for (int i = 1; i < ND; i++)
               if (m_disp[4*i +: 4] != 4'h0 || m_dpd[i]) top = i;
         end
         exp_fd = (p == 0);
         if (w < DC) begin
            exp_dig = 4'hF; exp_seg = 8'h00;
         end else begin
            exp_dig = ~(4'b0001 << d);
            exp_seg = (d > top) ? 8'h00 : {m_dpd[d], glyph[m_disp[4*d +: 4]]};
         end
         m_t++;
      end
      #1;
   endtask

   task automatic advance_to(input int target);
      int n = 0;
      while ((m_t % FRAME) != target && n < 2 * FRAME) begin tick(); n++; end
   endtask

   // Runs one full frame from the boundary edge, recording per-digit segments and model disagreements.
   task automatic run_frame(input bit ld, input logic [15:0] b, input logic [3:0] d);
      fd_cnt = 0; mism = 0; bad_msg = "";
      for (int k = 0; k < ND; k++) got[k] = 8'hEE;
      for (int i = 0; i < FRAME; i++) begin
         if (ld && i == 0) begin load = 1'b1; bcd_in = b; dp_in = d; end
         tick();
         load = 1'b0;
         trace[i] = dig_n;
         if (frame_done === 1'b1) fd_cnt++;
         if (dig_n !== exp_dig || seg !== exp_seg || frame_done !== exp_fd) begin
            if (mism == 0)
               bad_msg = $sformatf("cycle %0d dig_n=%b want %b seg=%h want %h fd=%b want %b",
                                   i, dig_n, exp_dig, seg, exp_seg, frame_done, exp_fd);
            mism++;
         end
         for (int k = 0; k < ND; k++) if (dig_n === ~(4'b0001 << k)) got[k] = seg;
      end
   endtask

   task automatic load_at(input int pos, input logic [15:0] b, input logic [3:0] d);
      advance_to(pos);
      load = 1'b1; bcd_in = b; dp_in = d;
      tick();
      load = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b1; bcd_in = 16'($urandom); dp_in = 4'($urandom);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (dig_n !== 4'hF || seg !== 8'h00 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: dig_n=%b seg=%h fd=%b, want 1111 00 0", dig_n, seg, frame_done);
         end
      end
      rst = 1'b0; load = 1'b0;
      tick();
      checks++;
      if (frame_done !== 1'b1 || dig_n !== 4'hF) begin
         failures++;
         $display("FAIL reset_release: fd=%b dig_n=%b, want 1 1111", frame_done, dig_n);
      end
      advance_to(0);
      run_frame(0, 16'h0, 4'h0);
      checks++;
      if (mism !== 0) begin failures++; $display("FAIL reset_frame_model: %s", bad_msg); end
      checks++;
      if (fd_cnt !== 1) begin failures++; $display("FAIL reset_fd_count: got %0d want 1", fd_cnt); end
      for (int k = 0; k < ND; k++) begin
         checks++;
         if (got[k] !== 8'h3F) begin
            failures++; $display("FAIL reset_discard d%0d: seg=%h want 3f", k, got[k]);
         end
      end
   endtask

   task automatic test_scan();
      for (int f = 0; f < 2; f++) begin
         run_frame(0, 16'h0, 4'h0);
         checks++;
         if (mism !== 0) begin failures++; $display("FAIL scan_model: %s", bad_msg); end
         checks++;
         if (fd_cnt !== 1) begin failures++; $display("FAIL scan_period: fd pulses=%0d want 1", fd_cnt); end
      end
      for (int i = 0; i < FRAME; i++) begin
         logic [3:0] want;
         want = (i % RD < DC) ? 4'hF : ~(4'b0001 << (i / RD));
         checks++;
         if (trace[i] !== want) begin
            failures++; $display("FAIL scan_order c%0d: dig_n=%b want %b", i, trace[i], want);
         end
      end
   endtask

   task automatic test_mid_load();
      load_at(18, 16'h1234, 4'h0);
      while ((m_t % FRAME) != 0) begin
         tick();
         if (dig_n !== 4'hF) begin
            checks++;
            if (seg !== 8'h3F) begin failures++; $display("FAIL mid_load_old: seg=%h want 3f", seg); end
         end
      end
      run_frame(0, 16'h0, 4'h0);
      checks++;
      if (mism !== 0) begin failures++; $display("FAIL mid_load_model: %s", bad_msg); end
      checks++;
      if (got[0] !== 8'h66 || got[1] !== 8'h4F || got[2] !== 8'h5B || got[3] !== 8'h06) begin
         failures++;
         $display("FAIL mid_load_new: d3..d0=%h %h %h %h want 06 5b 4f 66", got[3], got[2], got[1], got[0]);
      end
   endtask

   task automatic test_two_loads();
      logic [15:0] a, b;
      logic [3:0]  db;
      a = 16'($urandom); b = 16'($urandom); db = 4'($urandom);
      load_at(3, a, 4'($urandom));
      load_at(20, b, db);
      advance_to(0);
      run_frame(0, 16'h0, 4'h0);
      checks++;
      if (mism !== 0) begin failures++; $display("FAIL two_loads_model: %s", bad_msg); end
      for (int k = 0; k < ND; k++) begin
         checks++;
         if (got[k] !== {db[k], glyph[b[4*k +: 4]]}) begin
            failures++; $display("FAIL two_loads d%0d: seg=%h want %h", k, got[k], {db[k], glyph[b[4*k +: 4]]});
         end
      end
   endtask

   task automatic test_load_at_boundary();
      logic [15:0] x, y;
      logic [3:0]  dx, dy;
      x = 16'($urandom); y = ~x; dx = 4'($urandom); dy = ~dx;
      load_at(10, y, dy);
      advance_to(0);
      run_frame(1, x, dx);
      checks++;
      if (mism !== 0) begin failures++; $display("FAIL boundary_load_model: %s", bad_msg); end
      for (int k = 0; k < ND; k++) begin
         checks++;
         if (got[k] !== {dy[k], glyph[y[4*k +: 4]]}) begin
            failures++; $display("FAIL boundary_old d%0d: seg=%h want %h", k, got[k], {dy[k], glyph[y[4*k +: 4]]});
         end
      end
      run_frame(0, 16'h0, 4'h0);
      for (int k = 0; k < ND; k++) begin
         checks++;
         if (got[k] !== {dx[k], glyph[x[4*k +: 4]]}) begin
            failures++; $display("FAIL boundary_new d%0d: seg=%h want %h", k, got[k], {dx[k], glyph[x[4*k +: 4]]});
         end
      end
   endtask

   task automatic test_decode_edges();
      load_at(5, 16'hFA80, 4'b0010);
      advance_to(0);
      run_frame(0, 16'h0, 4'h0);
      checks++;
      if (got[3] !== 8'h00 || got[2] !== 8'h40 || got[1] !== 8'hFF || got[0] !== 8'h3F) begin
         failures++;
         $display("FAIL decode_edges: d3..d0=%h %h %h %h want 00 40 ff 3f", got[3], got[2], got[1], got[0]);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         logic [15:0] b;
         logic [3:0]  d;
         b = 16'($urandom); d = 4'($urandom);
         load_at($urandom_range(1, FRAME - 1), b, d);
         advance_to(0);
         run_frame(0, 16'h0, 4'h0);
         checks++;
         if (mism !== 0) begin failures++; $display("FAIL random_model it%0d: %s", it, bad_msg); end
         checks++;
         if (got[0] !== {d[0], glyph[b[3:0]]}) begin
            failures++; $display("FAIL random_d0 it%0d: seg=%h want %h", it, got[0], {d[0], glyph[b[3:0]]});
         end
      end
   endtask

   task automatic test_reset_mid();
      load_at(12, 16'h9876, 4'hF);
      tick();
      checks++;
      if (dig_n !== 4'b1101) begin failures++; $display("FAIL reset_mid_lit: dig_n=%b want 1101", dig_n); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (dig_n !== 4'hF || seg !== 8'h00 || frame_done !== 1'b0) begin
         failures++; $display("FAIL reset_mid_dark: dig_n=%b seg=%h fd=%b want 1111 00 0", dig_n, seg, frame_done);
      end
      tick();
      checks++;
      if (frame_done !== 1'b1) begin failures++; $display("FAIL reset_mid_restart: fd=%b want 1", frame_done); end
      advance_to(0);
      run_frame(0, 16'h0, 4'h0);
      checks++;
      if (mism !== 0) begin failures++; $display("FAIL reset_mid_model: %s", bad_msg); end
      for (int k = 0; k < ND; k++) begin
         checks++;
         if (got[k] !== 8'h3F) begin failures++; $display("FAIL reset_mid_discard d%0d: seg=%h want 3f", k, got[k]); end
      end
   endtask

`ifdef SEVEN_SEG_LZB_EN
   task automatic test_lzb();
      lz_blank = 1'b1;
      load_at(5, 16'h0050, 4'h0);
      advance_to(0);
      run_frame(0, 16'h0, 4'h0);
      checks++;
      if (mism !== 0) begin failures++; $display("FAIL lzb_model: %s", bad_msg); end
      checks++;
      if (got[3] !== 8'h00 || got[2] !== 8'h00 || got[1] !== 8'h6D || got[0] !== 8'h3F) begin
         failures++;
         $display("FAIL lzb_0050: d3..d0=%h %h %h %h want 00 00 6d 3f", got[3], got[2], got[1], got[0]);
      end
      checks++;
      if (trace[3*RD + DC] !== 4'b0111) begin
         failures++; $display("FAIL lzb_enable_timing: dig_n=%b want 0111", trace[3*RD + DC]);
      end
      load_at(5, 16'h0000, 4'h0);
      advance_to(0);
      run_frame(0, 16'h0, 4'h0);
      checks++;
      if (got[3] !== 8'h00 || got[2] !== 8'h00 || got[1] !== 8'h00 || got[0] !== 8'h3F) begin
         failures++;
         $display("FAIL lzb_0000: d3..d0=%h %h %h %h want 00 00 00 3f", got[3], got[2], got[1], got[0]);
      end
      lz_blank = 1'b0;
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h00};
      rst = 1'b1; load = 1'b0; bcd_in = 16'h0; dp_in = 4'h0; lz_blank = 1'b0;
      m_t = 0; m_pv = 0; m_pb = 16'h0; m_pd = 4'h0; m_disp = 16'h0; m_dpd = 4'h0;
      test_reset();
      test_scan();
      test_mid_load();
      test_two_loads();
      test_load_at_boundary();
      test_decode_edges();
      test_random();
      test_reset_mid();
`ifdef SEVEN_SEG_LZB_EN
      test_lzb();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Parametrised, time-multiplexed seven-segment display driver for the reaction-timer datapath. It holds an N-digit BCD value with per-digit decimal points and scans the digits one at a time. A programmable dwell time and a dead-time gap between digits prevent ghosting. New values are double-buffered so the display updates only at frame boundaries, which means a frame never shows a mix of old and new digits. The block sits between the timer/score logic and the top-level pin mapping onto the ck_io header.

## Interface
- NUM_DIGITS, 4: number of digits scanned; legal range 1..8
- REFRESH_DIV, 100000: clock cycles per digit slot (1 ms at 100 MHz); minimum 2
- DEAD_CYCLES, 1000: cycles at the start of each slot with all digits off; legal range 0..REFRESH_DIV-1

- clk  in  1  system clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- bcd_in  in  4*NUM_DIGITS  digit codes; nibble i drives digit i, where digit 0 is the rightmost
- dp_in  in  NUM_DIGITS  decimal point request per digit
- load  in  1  single-cycle strobe that captures bcd_in and dp_in into the pending register
- lz_blank  in  1  leading-zero blanking enable; port exists only with SEVEN_SEG_LZB_EN
- dig_n  out  NUM_DIGITS  digit enables, active-low; at most one bit low at a time
- seg  out  8  segments, active-high; bit0..6 = a..g, bit7 = dp
- frame_done  out  1  one-cycle pulse when the pending value is committed (start of the digit-0 slot)

## Operation
- State:
  - slot counter cnt, range 0..REFRESH_DIV-1
  - digit index idx, range 0..NUM_DIGITS-1
  - pending register plus pend_valid flag
  - display register
  - registered outputs
- Scan sequence:
  - cnt increments every cycle.
  - When cnt = REFRESH_DIV-1, cnt wraps to 0 and idx advances.
  - idx wraps from NUM_DIGITS-1 to 0.
- Frame boundary: the cycle where cnt and idx both wrap to 0, or the first cycle after reset.
  - If pend_valid = 1: pending is copied to the display register, pend_valid is cleared, and frame_done pulses.
  - If pend_valid = 0: the display register is unchanged and frame_done still pulses.
- Load behaviour:
  - load = 1 overwrites pending and sets pend_valid.
  - Repeated loads within one frame keep only the last value.
  - If load coincides with a boundary cycle, the boundary commits the pending contents from before that edge. The newly loaded value commits at the next boundary.
- Decode of display nibble (segments a..g):
  - 0–9: standard glyphs, e.g. 0 → 0x3F, 1 → 0x06, 8 → 0x7F.
  - 0xA–0xE: dash (g only, 0x40), used for the "too early" indication.
  - 0xF: blank (0x00).
- seg[7] = display dp bit of the current digit.
- Dead time: while cnt < DEAD_CYCLES, dig_n is all-ones and seg is 0x00. Otherwise dig_n[idx] = 0 and seg = decode of digit idx.

## Timing
- Reset values:
  - dig_n all-ones, seg 0x00, frame_done 0.
  - cnt 0, idx 0.
  - Display register all 0, dp all 0, pend_valid 0.
- The first rising edge with rst = 0 is slot cycle 0 of digit 0 and is a frame boundary, so frame_done pulses one cycle later.
- Outputs are registered: they lag the (idx, cnt) state by exactly one cycle.
- Load-to-display latency: from the load cycle to the next boundary plus 1 cycle. The worst case is NUM_DIGITS*REFRESH_DIV + 1 cycles.
- Frame period is NUM_DIGITS*REFRESH_DIV cycles. frame_done pulses once per frame.
- rst asserted mid-scan: on the next edge all state returns to reset values. Any pending load is discarded, and outputs go dark in that same cycle.
- DEAD_CYCLES = 0: a digit is lit in every cycle. The digit enable moves directly from one bit to the next with no all-off cycle.

## Configuration
- SEVEN_SEG_LZB_EN defined:
  - The lz_blank port exists.
  - When lz_blank = 1, digits from NUM_DIGITS-1 downward are blanked while their display nibble is 0 and their dp bit is 0, stopping at the first digit that fails this test.
  - Digit 0 is never blanked.
  - A blanked digit drives seg = 0x00, but its dig_n slot timing is unchanged.
  - Blanking is evaluated from the display register, so it changes only at frame boundaries.
- SEVEN_SEG_LZB_EN undefined: the port is absent and all digits are decoded normally.

## Test plan
- Reset:
  - Hold rst = 1 for 3 cycles with load = 1 → dig_n = 4'b1111, seg = 0x00, frame_done = 0 throughout.
  - Release rst → frame_done pulses once.
- Scan order and timing (NUM_DIGITS = 4, REFRESH_DIV = 8, DEAD_CYCLES = 2):
  - Per slot, dig_n is 1111 for 2 cycles, then 1110/1101/1011/0111 for 6 cycles.
  - Frame period is 32 cycles.
- Mid-frame load:
  - Load 0x1234 during digit-2 slot → old value (0x0000) shown until next boundary.
  - After the boundary, digit 0 shows 0x66 (4) and digit 3 shows 0x06 (1).
  - Two loads in one frame → only the second is displayed.
- Decode edges:
  - bcd_in = 0xFA80, dp_in = 4'b0010.
  - Expected: digit 3 seg = 0x00, digit 2 = 0x40, digit 1 = 0xFF, digit 0 = 0x3F.
- Leading-zero blanking (SEVEN_SEG_LZB_EN, lz_blank = 1):
  - 0x0050 → digits 3 and 2 blank, digit 1 = 0x6D, digit 0 = 0x3F.
  - 0x0000 → only digit 0 lit, showing 0x3F.
- Reset mid-operation:
  - Assert rst during digit-1 dwell with pend_valid = 1.
  - Expected: outputs dark the next cycle; after release, display shows 0x0000 (pending discarded).
